// File: rtl/line_fill_arbiter.sv
// rtl/line_fill_arbiter.sv - two-port line-fill arbiter onto one downstream cacheline port
//
// Serialises whole-line transactions from two requesters onto a single
// downstream port, one transaction outstanding at a time.
//   port 0 : instruction linebuffer, read-only, response killable by flush
//   port 1 : data cache, read or write-back (write wins if both asserted)
// Arbitration is fixed-priority (PRIO_PORT) with a starvation guard: once
// PRIO_PORT has won MAX_STREAK back-to-back contested grants, the other port
// gets the next contested grant.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   flush                    kills delivery of an in-flight port-0 response
//   p0_addr/p0_read          port 0 request (level, held until p0_resp)
//   p0_rdata/p0_resp         port 0 returned line / completion pulse
//   p1_addr/p1_read/p1_write port 1 request (level, held until p1_resp)
//   p1_wdata                 port 1 write-back line
//   p1_rdata/p1_resp         port 1 returned line / completion pulse
//   dfp_addr/dfp_wdata       latched downstream address / write line
//   dfp_read/dfp_write       downstream command, held until dfp_resp
//   dfp_rdata/dfp_resp       downstream returned line / completion pulse

module line_fill_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int LINE_W     = 256,
    parameter int PRIO_PORT  = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic              p0_read,
    output logic [LINE_W-1:0] p0_rdata,
    output logic              p0_resp,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic              p1_read,
    input  logic              p1_write,
    input  logic [LINE_W-1:0] p1_wdata,
    output logic [LINE_W-1:0] p1_rdata,
    output logic              p1_resp,
    output logic [ADDR_W-1:0] dfp_addr,
    output logic              dfp_read,
    output logic              dfp_write,
    output logic [LINE_W-1:0] dfp_wdata,
    input  logic [LINE_W-1:0] dfp_rdata,
    input  logic              dfp_resp
);

    localparam int   SW   = $clog2(MAX_STREAK + 1);
    localparam logic PRIO = (PRIO_PORT != 0);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

    state_t            state;
    state_t            state_nx;
    logic [SW-1:0]     streak;
    logic              last_grant;
    logic              killed;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              write_q;

    logic req0;
    logic req1;
    logic grant_v;
    logic grant_port;
    logic other_req;

    assign req0 = p0_read;
    assign req1 = p1_read | p1_write;

    // Winner selection; only meaningful in IDLE.
    always_comb begin
        grant_v    = 1'b0;
        grant_port = 1'b0;
        if (state == IDLE) begin
            if (req0 && req1) begin
                grant_v = 1'b1;
                // Starvation guard: hand the contested slot to the other port
                // once the priority port has used up its streak.
                if (streak == STREAK_MAX && last_grant == PRIO)
                    grant_port = ~PRIO;
                else
                    grant_port = PRIO;
            end else if (req0) begin
                grant_v    = 1'b1;
                grant_port = 1'b0;
            end else if (req1) begin
                grant_v    = 1'b1;
                grant_port = 1'b1;
            end
        end
    end

    assign other_req = grant_port ? req0 : req1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant_v) state_nx = grant_port ? BUSY1 : BUSY0;
            BUSY0,
            BUSY1:   if (dfp_resp) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Grant bookkeeping and latched downstream command.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak     <= '0;
            last_grant <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
        end else if (grant_v) begin
            addr_q     <= grant_port ? p1_addr : p0_addr;
            write_q    <= grant_port & p1_write;
            if (grant_port && p1_write)
                wdata_q <= p1_wdata;
            last_grant <= grant_port;
            if (grant_port == last_grant && other_req)
                streak <= (streak == STREAK_MAX) ? streak : streak + 1'b1;
            else
                streak <= SW'(1);
        end
    end

    // Port-0 kill flag: the memory transaction cannot be aborted, so a flush
    // only suppresses the eventual p0_resp.
    always_ff @(posedge clk) begin
        if (rst) begin
            killed <= 1'b0;
        end else begin
            case (state)
                IDLE:    killed <= grant_v && !grant_port && flush;
                BUSY0:   killed <= dfp_resp ? 1'b0 : (killed | flush);
                default: killed <= 1'b0;
            endcase
        end
    end

    // Outputs.
    always_comb begin
        dfp_addr  = addr_q;
        dfp_wdata = wdata_q;
        dfp_read  = (state != IDLE) && !write_q;
        dfp_write = (state != IDLE) &&  write_q;
        p0_resp   = (state == BUSY0) && dfp_resp && !killed && !flush && !rst;
        p1_resp   = (state == BUSY1) && dfp_resp && !rst;
        p0_rdata  = p0_resp ? dfp_rdata : '0;
        p1_rdata  = p1_resp ? dfp_rdata : '0;
    end

endmodule

// File: tb/tb_line_fill_arbiter.sv
// tb/tb_line_fill_arbiter.sv - randomized scoreboard bench for line_fill_arbiter

module tb_line_fill_arbiter;

    localparam int MAX_STREAK = 4;
    localparam int PRIO       = 1;
    localparam int N_CYC      = 3700;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [31:0]  p0_addr;
    logic         p0_read;
    logic [255:0] p0_rdata;
    logic         p0_resp;
    logic [31:0]  p1_addr;
    logic         p1_read;
    logic         p1_write;
    logic [255:0] p1_wdata;
    logic [255:0] p1_rdata;
    logic         p1_resp;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;

    line_fill_arbiter #(
        .ADDR_W(32), .LINE_W(256), .PRIO_PORT(PRIO), .MAX_STREAK(MAX_STREAK)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .p0_addr(p0_addr), .p0_read(p0_read), .p0_rdata(p0_rdata), .p0_resp(p0_resp),
        .p1_addr(p1_addr), .p1_read(p1_read), .p1_write(p1_write), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_resp(p1_resp),
        .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
        .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit done  = 0;

    // Reference state: what transaction memory should be seeing and for whom.
    bit           m_busy, m_port, m_wr, m_killed;
    int           streak, last_port, lat;
    logic [31:0]  m_addr;
    logic [255:0] m_wdata;
    logic [255:0] mem [logic [31:0]];
    logic [255:0] exp0 [$];
    logic [255:0] exp1 [$];

    // Requester state.
    bit           pend0, pend1, drop0, drop1, op_rd1, op_wr1;
    logic [31:0]  addr0, addr1;
    int           ev;
    int           p0_grants, p1_grants;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    function automatic logic [31:0] rand_line();
        return 32'h0000_1000 + 32'($urandom_range(0, 15)) * 32;
    endfunction

    // Advance the reference at a clock edge using the inputs of the cycle just ended.
    task automatic model_edge();
        bit r0, r1, w;
        if (rst) begin
            m_busy = 0; m_killed = 0; m_wr = 0; m_port = 0;
            streak = 0; last_port = 0; lat = 0;
            m_addr = '0; m_wdata = '0;
            pend0 = 0; pend1 = 0; drop0 = 0; drop1 = 0;
            exp0.delete(); exp1.delete();
        end else if (!m_busy) begin
            r0 = p0_read;
            r1 = p1_read | p1_write;
            if (r0 || r1) begin
                if (r0 && r1)
                    w = (streak == MAX_STREAK && last_port == PRIO) ? bit'(1 - PRIO) : bit'(PRIO);
                else
                    w = r1;
                if (int'(w) == last_port && (w ? r0 : r1))
                    streak = (streak + 1 > MAX_STREAK) ? MAX_STREAK : streak + 1;
                else
                    streak = 1;
                last_port = int'(w);
                m_busy = 1;
                m_port = w;
                m_wr   = w && p1_write;
                m_addr = w ? p1_addr : p0_addr;
                if (m_wr) m_wdata = p1_wdata;
                m_killed = !w && flush;
                lat = $urandom_range(1, 3);
                if (w) begin
                    p1_grants++;
                    exp1.push_back(mem_rd(m_addr));
                end else begin
                    p0_grants++;
                    if (!m_killed) exp0.push_back(mem_rd(m_addr));
                end
            end
        end else if (dfp_resp) begin
            if (m_wr) mem[m_addr] = m_wdata;
            m_busy = 0;
            m_killed = 0;
            if (m_port) begin pend1 = 0; drop1 = 0; end
            else        begin pend0 = 0; drop0 = 0; end
        end else if (!m_port && flush && !m_killed) begin
            m_killed = 1;
            void'(exp0.pop_back());
        end
    endtask

    task automatic drive(input int cyc);
        int load;
        int op;
        load = (cyc < 1500) ? 30 : (cyc < 3000) ? 100 : (cyc < 3600) ? 50 : 0;
        rst = (cyc < 2);
        dfp_resp = 0;
        flush = 0;
        dfp_rdata = {8{$urandom}};
        if (cyc >= 3000 && ev == 0 && m_busy && m_port) begin
            rst = 1;
            ev = 1;
        end else if (ev == 1) begin
            dfp_resp = 1;
            ev = 2;
        end else if (m_busy) begin
            if (lat <= 1) begin
                dfp_resp = 1;
                dfp_rdata = mem_rd(m_addr);
            end else begin
                lat--;
            end
        end else if ($urandom_range(0, 15) == 0) begin
            dfp_resp = 1;
        end
        if (!dfp_resp && !rst && $urandom_range(0, 9) == 0) flush = 1;

        if (!pend0 && $urandom_range(0, 99) < load) begin
            pend0 = 1; drop0 = 0; addr0 = rand_line();
        end else if (pend0 && m_busy && !m_port && $urandom_range(0, 19) == 0) begin
            drop0 = 1;
        end
        if (!pend1 && $urandom_range(0, 99) < load) begin
            pend1 = 1; drop1 = 0; addr1 = rand_line();
            op = $urandom_range(0, 2);
            op_rd1 = (op != 1);
            op_wr1 = (op != 0);
        end else if (pend1 && m_busy && m_port && $urandom_range(0, 19) == 0) begin
            drop1 = 1;
        end
        p0_read  = pend0 && !drop0;
        p0_addr  = addr0;
        p1_read  = pend1 && !drop1 && op_rd1;
        p1_write = pend1 && !drop1 && op_wr1;
        p1_addr  = addr1;
        p1_wdata = {8{$urandom}};
    endtask

    // Monitor: compare DUT outputs mid-cycle against the reference and scoreboard.
    always @(negedge clk) begin
        if (!done) begin
            chk("dfp_read",  {255'b0, dfp_read},  {255'b0, m_busy && !m_wr});
            chk("dfp_write", {255'b0, dfp_write}, {255'b0, m_busy && m_wr});
            chk("dfp_addr",  {224'b0, dfp_addr},  {224'b0, m_addr});
            chk("dfp_wdata", dfp_wdata, m_wdata);
            chk("p0_resp", {255'b0, p0_resp},
                {255'b0, m_busy && !m_port && dfp_resp && !m_killed && !rst});
            chk("p1_resp", {255'b0, p1_resp},
                {255'b0, m_busy && m_port && dfp_resp && !rst});
            if (p0_resp) begin
                if (exp0.size() == 0) chk("p0_resp_unexpected", 256'd1, 256'd0);
                else                  chk("p0_rdata", p0_rdata, exp0.pop_front());
            end else begin
                chk("p0_rdata_idle", p0_rdata, 256'd0);
            end
            if (p1_resp) begin
                if (exp1.size() == 0) chk("p1_resp_unexpected", 256'd1, 256'd0);
                else                  chk("p1_rdata", p1_rdata, exp1.pop_front());
            end else begin
                chk("p1_rdata_idle", p1_rdata, 256'd0);
            end
        end
    end

    initial begin
        rst = 1; flush = 0; p0_read = 0; p0_addr = '0;
        p1_read = 0; p1_write = 0; p1_addr = '0; p1_wdata = '0;
        dfp_rdata = '0; dfp_resp = 0;
        m_busy = 0; m_killed = 0; m_wr = 0; m_port = 0;
        m_addr = '0; m_wdata = '0; streak = 0; last_port = 0; lat = 0;
        pend0 = 0; pend1 = 0; drop0 = 0; drop1 = 0; op_rd1 = 0; op_wr1 = 0;
        addr0 = '0; addr1 = '0; ev = 0; p0_grants = 0; p1_grants = 0;
        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(posedge clk);
            model_edge();
            #1;
            drive(cyc);
        end
        @(negedge clk);
        #1;
        done = 1;
        chk("reset_event_reached", 256'(ev), 256'd2);
        chk("drained_busy", {255'b0, m_busy}, 256'd0);
        chk("exp0_empty", 256'(exp0.size()), 256'd0);
        chk("exp1_empty", 256'(exp1.size()), 256'd0);
        chk("p0_ever_granted", {255'b0, p0_grants > 0}, 256'd1);
        chk("p1_ever_granted", {255'b0, p1_grants > 0}, 256'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
